mp3_data_rx: RTL and testbench

//  Receiving end of the MP3-chip serial data interface driven by spi2 (mp3_clk/mp3_dat/mp3_sync).

---
 rtl/mp3_data_rx.sv | 166 ++++++++++++++++
 tb/tb_mp3_data_rx.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mp3_data_rx.sv
// mp3_data_rx: oversampling serial byte receiver with FWFT FIFO.
// Drives dreq back to the transmitter from FIFO free space.
module mp3_data_rx #(
  parameter int AW       = 4,
  parameter int REQ_FREE = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sck,
  input  logic          sdi,
  input  logic          bsync,
  output logic          dreq,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  input  logic          rd_strobe,
  output logic [AW:0]   fifo_level,
  output logic          overflow,
  output logic          frame_err,
  input  logic          clr_err
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {
    HUNT,
    SHIFT
  } state_t;

  logic          sck_m_q, sck_s_q, sck_d_q;
  logic          sdi_m_q, sdi_s_q;
  logic          bs_m_q, bs_s_q;
  logic          rise;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [6:0]    shift_q, shift_d;
  logic          push;
  logic          ferr_set;
  logic [7:0]    byte_w;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW-1:0] wr_ptr_d, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          pop, full, wr_en, ovf_set;
  logic          dreq_q, dreq_d;
  logic          ovf_q, ovf_d;
  logic          ferr_q, ferr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_m_q <= 1'b0;
      sck_s_q <= 1'b0;
      sck_d_q <= 1'b0;
      sdi_m_q <= 1'b0;
      sdi_s_q <= 1'b0;
      bs_m_q  <= 1'b0;
      bs_s_q  <= 1'b0;
    end else begin
      sck_m_q <= sck;
      sck_s_q <= sck_m_q;
      sck_d_q <= sck_s_q;
      sdi_m_q <= sdi;
      sdi_s_q <= sdi_m_q;
      bs_m_q  <= bsync;
      bs_s_q  <= bs_m_q;
    end
  end

  assign rise   = sck_s_q & ~sck_d_q;
  assign byte_w = {shift_q, sdi_s_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    if (rise) begin
      unique case (state_q)
        HUNT: begin
          if (bs_s_q) begin
            shift_d = {6'b0, sdi_s_q};
            cnt_d   = 3'd1;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (bs_s_q) begin
            // Sync mid-byte: drop the partial byte, restart on this bit
            ferr_set = 1'b1;
            shift_d  = {6'b0, sdi_s_q};
            cnt_d    = 3'd1;
          end else begin
            shift_d = {shift_q[5:0], sdi_s_q};
            if (cnt_q == 3'd7) begin
              push    = 1'b1;
              cnt_d   = 3'd0;
              state_d = HUNT;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      cnt_q   <= 3'd0;
      shift_q <= 7'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    pop      = rd_strobe & rd_valid;
    full     = (count_q == (AW+1)'(DEPTH));
    wr_en    = push & (~full | pop);
    ovf_set  = push & full & ~pop;
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    dreq_d   = (DEPTH - int'(count_d)) >= REQ_FREE;
    ovf_d    = ovf_set | (ovf_q & ~clr_err);
    ferr_d   = ferr_set | (ferr_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'd0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dreq_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= byte_w;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dreq_q   <= dreq_d;
      ovf_q    <= ovf_d;
      ferr_q   <= ferr_d;
    end
  end

  assign rd_data    = mem_q[rd_ptr_q];
  assign rd_valid   = (count_q != '0);
  assign fifo_level = count_q;
  assign dreq       = dreq_q;
  assign overflow   = ovf_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_mp3_data_rx.sv
// tb_mp3_data_rx: directed bench for mp3_data_rx.
// Serial stimulus at sck = 4 clk high / 4 clk low.
module tb_mp3_data_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b0;
  logic       sdi = 1'b0;
  logic       bsync = 1'b0;
  logic       dreq;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_strobe = 1'b0;
  logic [4:0] fifo_level;
  logic       overflow;
  logic       frame_err;
  logic       clr_err = 1'b0;

  int pass_cnt = 0;
  int total = 0;

  mp3_data_rx #(.AW(4), .REQ_FREE(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .sck        (sck),
    .sdi        (sdi),
    .bsync      (bsync),
    .dreq       (dreq),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_strobe  (rd_strobe),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .frame_err  (frame_err),
    .clr_err    (clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One serial bit; caller sits at a negedge on entry and exit.
  task automatic send_bit(input logic d, input logic bs, input bit last,
                          input bit lat, input bit popit);
    sck = 1'b0;
    sdi = d;
    bsync = bs;
    repeat (4) @(negedge clk);
    sck = 1'b1;
    if (last) begin
      @(negedge clk);
      @(negedge clk);
      if (lat) chk("lat_pre", 32'(rd_valid), 32'd0);
      if (popit) rd_strobe = 1'b1;
      @(negedge clk);
      if (lat) chk("lat_post", 32'(rd_valid), 32'd1);
      rd_strobe = 1'b0;
      @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit lat,
                           input bit popit);
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i], (i == 7), (i == 0), lat, popit);
    end
  endtask

  task automatic pop_n(input int n);
    rd_strobe = 1'b1;
    repeat (n) @(negedge clk);
    rd_strobe = 1'b0;
  endtask

  initial begin
    logic [7:0] junk;
    junk = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dreq", 32'(dreq), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("dreq_rel", 32'(dreq), 32'd1);
    @(negedge clk);

    // 1: single byte, latency
    send_byte(8'hA5, 1'b1, 1'b0);
    chk("t1_data", 32'(rd_data), 32'hA5);
    chk("t1_level", 32'(fifo_level), 32'd1);
    pop_n(1);
    chk("t1_popped", 32'(fifo_level), 32'd0);

    // 2: fill, dreq threshold, overflow
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i), 1'b0, 1'b0);
      if (i == 11) chk("t2_dreq12", 32'(dreq), 32'd1);
      if (i == 12) chk("t2_dreq13", 32'(dreq), 32'd0);
    end
    chk("t2_level", 32'(fifo_level), 32'd16);
    chk("t2_ovf0", 32'(overflow), 32'd0);
    send_byte(8'h10, 1'b0, 1'b0);
    chk("t2_ovf1", 32'(overflow), 32'd1);
    chk("t2_level_full", 32'(fifo_level), 32'd16);
    chk("t2_head", 32'(rd_data), 32'h00);

    // 3: drain in order, extra strobe ignored
    rd_strobe = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t3_data", 32'(rd_data), 32'(i));
      @(negedge clk);
    end
    chk("t3_valid", 32'(rd_valid), 32'd0);
    chk("t3_level", 32'(fifo_level), 32'd0);
    @(negedge clk);
    rd_strobe = 1'b0;
    chk("t3_extra", 32'(fifo_level), 32'd0);
    chk("t3_dreq", 32'(dreq), 32'd1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("t3_ovf_clr", 32'(overflow), 32'd0);

    // 4: bsync mid-byte, then clean 0x3C
    for (int i = 7; i >= 5; i--) begin
      send_bit(junk[i], (i == 7), 1'b0, 1'b0, 1'b0);
    end
    chk("t4_ferr0", 32'(frame_err), 32'd0);
    send_byte(8'h3C, 1'b0, 1'b0);
    chk("t4_ferr1", 32'(frame_err), 32'd1);
    chk("t4_level", 32'(fifo_level), 32'd1);
    chk("t4_data", 32'(rd_data), 32'h3C);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("t4_ferr_clr", 32'(frame_err), 32'd0);
    pop_n(1);

    // 5: full FIFO, push and pop in one cycle
    for (int i = 0; i < 16; i++) begin
      send_byte(8'h20 + 8'(i), 1'b0, 1'b0);
    end
    chk("t5_full", 32'(fifo_level), 32'd16);
    send_byte(8'h55, 1'b0, 1'b1);
    chk("t5_level", 32'(fifo_level), 32'd16);
    chk("t5_ovf", 32'(overflow), 32'd0);
    chk("t5_head", 32'(rd_data), 32'h21);
    pop_n(15);
    chk("t5_tail", 32'(rd_data), 32'h55);
    chk("t5_lvl1", 32'(fifo_level), 32'd1);
    pop_n(1);

    // 6: reset mid-byte, then 0x81
    for (int i = 7; i >= 3; i--) begin
      send_bit(junk[i], (i == 7), 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b1;
    sck = 1'b0;
    sdi = 1'b0;
    bsync = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_level", 32'(fifo_level), 32'd0);
    send_byte(8'h81, 1'b0, 1'b0);
    chk("t6_level", 32'(fifo_level), 32'd1);
    chk("t6_data", 32'(rd_data), 32'h81);
    chk("t6_ovf", 32'(overflow), 32'd0);
    chk("t6_ferr", 32'(frame_err), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
